fsa_rd_sched: RTL and testbench

FSA_RD_SCHED -- requirements
Module: fsa_rd_sched

---
 rtl/fsa_rd_sched.sv | 129 ++++++++++++
 tb/tb_fsa_rd_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fsa_rd_sched.sv
// fsa_rd_sched: two-requester burst read scheduler for a shared frame buffer port.
// Define FSA_RD_SCHED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module fsa_rd_sched #(
   parameter int C_IMG_WW = 8,
   parameter int BR_AW    = 8,
   parameter int BR_DW    = 35
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [C_IMG_WW-1:0] width,
   input  logic                req0_valid,
   input  logic                req0_sof,
   output logic                req0_ready,
   output logic                req0_dvalid,
   output logic                req0_dlast,
   input  logic                req1_valid,
   input  logic                req1_sof,
   output logic                req1_ready,
   output logic                req1_dvalid,
   output logic                req1_dlast,
   output logic [BR_DW-1:0]    req_data,
   output logic                m_sof,
   output logic                m_en,
   output logic [BR_AW-1:0]    m_addr,
   input  logic [BR_DW-1:0]    m_data,
   output logic                busy,
   output logic                grant
);
   typedef enum logic [1:0] {IDLE, SOF, READ, DRAIN} state_t;
   localparam logic [C_IMG_WW-1:0] ONE = C_IMG_WW'(1);
   state_t state_q, state_d;
   logic [C_IMG_WW-1:0] cnt_q, cnt_d, wid_q, wid_d;
   logic grant_q, grant_d, busy_q, busy_d, m_sof_q, m_sof_d, m_en_q, m_en_d, dr_q, dr_d;
   logic en1_q, en2_q, last1_q, last2_q;
   logic [BR_DW-1:0] data_q;
   logic g1, accept, sof_sel, last_addr;
`ifdef FSA_RD_SCHED_PRIO_EN
   assign g1 = req1_valid & ~req0_valid;
`else
   logic ptr_q, ptr_d;
   assign g1 = req1_valid & (~req0_valid | ~ptr_q);
`endif
   assign req1_ready  = (state_q == IDLE) & g1;
   assign req0_ready  = (state_q == IDLE) & req0_valid & ~g1;
   assign accept      = req0_ready | req1_ready;
   assign sof_sel     = g1 ? req1_sof : req0_sof;
   assign last_addr   = cnt_q == wid_q - ONE;
   assign m_sof       = m_sof_q;
   assign m_en        = m_en_q;
   assign m_addr      = BR_AW'(cnt_q);
   assign busy        = busy_q;
   assign grant       = grant_q;
   assign req_data    = data_q;
   assign req0_dvalid = en2_q & ~grant_q;
   assign req1_dvalid = en2_q & grant_q;
   assign req0_dlast  = last2_q & ~grant_q;
   assign req1_dlast  = last2_q & grant_q;
   // next-state: arbitration/accept in IDLE, address walk in READ, two-cycle pipeline drain
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wid_d   = wid_q;
      grant_d = grant_q;
      dr_d    = dr_q;
`ifndef FSA_RD_SCHED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: if (accept) begin
            grant_d = g1;
            wid_d   = width;
`ifndef FSA_RD_SCHED_PRIO_EN
            ptr_d   = g1;
`endif
            state_d = sof_sel ? SOF : (width != '0 ? READ : IDLE);
         end
         SOF:  state_d = wid_q != '0 ? READ : IDLE;
         READ: begin
            cnt_d   = last_addr ? '0 : cnt_q + ONE;
            state_d = last_addr ? DRAIN : READ;
         end
         default: begin
            dr_d    = ~dr_q;
            state_d = dr_q ? IDLE : DRAIN;
         end
      endcase
      busy_d  = state_d != IDLE;
      m_sof_d = state_d == SOF;
      m_en_d  = state_d == READ;
   end
   // state, registered outputs and the two-stage read-data pipeline
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wid_q   <= '0;
         grant_q <= 1'b0;
         busy_q  <= 1'b0;
         m_sof_q <= 1'b0;
         m_en_q  <= 1'b0;
         dr_q    <= 1'b0;
`ifndef FSA_RD_SCHED_PRIO_EN
         ptr_q   <= 1'b1;
`endif
         en1_q   <= 1'b0;
         en2_q   <= 1'b0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wid_q   <= wid_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         m_sof_q <= m_sof_d;
         m_en_q  <= m_en_d;
         dr_q    <= dr_d;
`ifndef FSA_RD_SCHED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
         en1_q   <= m_en_q;
         en2_q   <= en1_q;
         last1_q <= m_en_q & last_addr;
         last2_q <= last1_q;
         if (en1_q) data_q <= m_data;
      end
   end
endmodule

// File: tb/tb_fsa_rd_sched.sv
// tb_fsa_rd_sched: randomized and directed bench with a cycle-indexed expectation model
module tb_fsa_rd_sched;
   localparam int W = 8, AW = 8, DW = 35, NC = 8192;
   logic clk = 0, resetn = 1;
   logic [W-1:0] width = '0;
   logic r0v = 0, r1v = 0, r0s = 0, r1s = 0;
   logic r0rdy, r1rdy, r0dv, r1dv, r0dl, r1dl, m_sof, m_en, busy, grant;
   logic [DW-1:0] req_data, m_data;
   logic [AW-1:0] m_addr;
   int checks = 0, failures = 0, cyc = 0, idle_from = 0;
   bit ptr = 1, mgrant = 0;
   bit esof[NC], een[NC], ebusy[NC], edv0[NC], edv1[NC], el0[NC], el1[NC];
   int eaddr[NC], edata[NC];

   fsa_rd_sched #(.C_IMG_WW(W), .BR_AW(AW), .BR_DW(DW)) dut (
      .clk(clk), .resetn(resetn), .width(width),
      .req0_valid(r0v), .req0_sof(r0s), .req0_ready(r0rdy), .req0_dvalid(r0dv), .req0_dlast(r0dl),
      .req1_valid(r1v), .req1_sof(r1s), .req1_ready(r1rdy), .req1_dvalid(r1dv), .req1_dlast(r1dl),
      .req_data(req_data), .m_sof(m_sof), .m_en(m_en), .m_addr(m_addr), .m_data(m_data),
      .busy(busy), .grant(grant));

   always #5 clk = ~clk;
   // buffer model: returns addr+100 one cycle after the read
   always @(posedge clk) m_data <= DW'(m_addr) + DW'(100);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic do_reset();
      r0v = 0; r1v = 0; r0s = 0; r1s = 0;
      resetn = 0;
      #2;
      chk("rst_sof", m_sof, 0);     chk("rst_en", m_en, 0);
      chk("rst_addr", m_addr, 0);   chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);   chk("rst_data", req_data, 0);
      chk("rst_dv0", r0dv, 0);      chk("rst_dv1", r1dv, 0);
      chk("rst_dl0", r0dl, 0);      chk("rst_dl1", r1dl, 0);
      @(posedge clk); #1;
      resetn = 1;
      for (int j = cyc; j < NC; j++) begin
         esof[j] = 0; een[j] = 0; ebusy[j] = 0; edv0[j] = 0; edv1[j] = 0; el0[j] = 0; el1[j] = 0;
      end
      cyc++;
      idle_from = cyc; ptr = 1; mgrant = 0;
   endtask

   task automatic step(input bit v0, input bit v1, input bit s0, input bit s1, input int w);
      bit e0, e1, s;
      int k, last_c;
      r0v = v0; r1v = v1; r0s = s0; r1s = s1; width = W'(w);
      @(negedge clk);
      e0 = 0; e1 = 0;
      if (cyc >= idle_from) begin
`ifdef FSA_RD_SCHED_PRIO_EN
         e1 = v1 && !v0;
`else
         e1 = v1 && (!v0 || !ptr);
`endif
         e0 = v0 && !e1;
      end
      chk("ready0", r0rdy, e0);       chk("ready1", r1rdy, e1);
      chk("m_sof", m_sof, esof[cyc]); chk("m_en", m_en, een[cyc]);
      if (een[cyc]) chk("m_addr", m_addr, eaddr[cyc]);
      chk("busy", busy, ebusy[cyc]);  chk("grant", grant, mgrant);
      chk("dvalid0", r0dv, edv0[cyc]); chk("dvalid1", r1dv, edv1[cyc]);
      chk("dlast0", r0dl, el0[cyc]);   chk("dlast1", r1dl, el1[cyc]);
      if (edv0[cyc] || edv1[cyc]) chk("req_data", req_data, edata[cyc]);
      if (e0 || e1) begin
         k = cyc + 1;
         s = e1 ? s1 : s0;
         if (s) esof[k] = 1;
         for (int i = 0; i < w; i++) begin
            een[k + s + i] = 1;
            eaddr[k + s + i] = i;
            edata[k + s + i + 2] = i + 100;
            if (e1) edv1[k + s + i + 2] = 1; else edv0[k + s + i + 2] = 1;
            if (i == w - 1) begin
               if (e1) el1[k + s + i + 2] = 1; else el0[k + s + i + 2] = 1;
            end
         end
         last_c = (w > 0) ? k + s + w + 2 : k + s;
         for (int j = k; j < last_c; j++) ebusy[j] = 1;
         idle_from = last_c;
         mgrant = e1;
         ptr = e1;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      #1;
      do_reset();
      step(1, 0, 1, 0, 40);
      repeat (48) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 40);
      repeat (10) step(1, 0, 0, 0, 40);
      repeat (45) step(1, 0, 0, 0, 8);
      repeat (15) step(0, 0, 0, 0, 8);
      repeat (40) step(1, 1, 0, 0, 4);
      repeat (10) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      repeat (4) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 40);
      repeat (11) step(0, 0, 0, 0, 0);
      do_reset();
      step(1, 0, 0, 0, 5);
      repeat (10) step(0, 0, 0, 0, 0);
      repeat (1500) step(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                         ($urandom % 4) == 0,
                         ($urandom % 8 == 0) ? $urandom_range(7, 20) : $urandom_range(0, 5));
      repeat (30) step(0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
